trivium_stream_ctrl: RTL and testbench

Bus-master front end that drives the Trivium core's PLB-style slave interface, so the cipher can be fed as a word stream without software polling. It accepts 32-bit words on a valid/ready input stream and buffers them in an input FIFO. It issues init, input-write, status-poll and output-read accesses to the core, and buffers results in an output FIFO presented on a valid/ready output stream. Key/IV are loaded by software before start; this block only sequences init and data.

---
 rtl/trivium_stream_ctrl.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_trivium_stream_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_stream_ctrl.sv
// trivium_stream_ctrl: bus-master front end that streams 32-bit words through the
// Trivium core's PLB-style slave port. Words arrive on a valid/ready stream, are
// queued, written to the core, polled for completion and read back into a
// show-ahead output queue. Key/IV loading is left to software.
//
// Build option: define TRIVIUM_STREAM_TIMEOUT_EN to abort any core access that
// goes unacknowledged for TIMEOUT_CYCLES cycles (sticky err_o, FSM back to IDLE).
// Without it accesses wait indefinitely and err_o is tied low.
module trivium_stream_ctrl #(
    parameter int FIFO_AW        = 3,
    parameter int POLL_GAP       = 4,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic        bus2ip_clk_i,
    input  logic        n_rst_s,
    input  logic        start_i,
    input  logic [31:0] s_dat_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic [31:0] m_dat_o,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [3:0]  core_addr_o,
    output logic        core_rnw_o,
    output logic [31:0] core_dat_o,
    output logic [3:0]  core_be_o,
    output logic [8:0]  core_rdce_o,
    output logic [8:0]  core_wrce_o,
    input  logic [31:0] core_dat_i,
    input  logic        core_rdack_i,
    input  logic        core_wrack_i,
    output logic        busy_o,
    output logic [15:0] words_done_o,
    output logic        err_o
);

    // Elaboration-time guard against unusable parameter values.
    if (FIFO_AW < 1 || POLL_GAP < 1 || POLL_GAP > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("trivium_stream_ctrl: parameter out of range");
    end

    localparam int              DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    // Core register map: control/status at 0, data-in at 7, data-out at 8.
    localparam logic [3:0] A_CTRL  = 4'd0;
    localparam logic [3:0] A_DIN   = 4'd7;
    localparam logic [3:0] A_DOUT  = 4'd8;
    localparam logic [8:0] CE_CTRL = 9'h001;
    localparam logic [8:0] CE_DIN  = 9'h080;
    localparam logic [8:0] CE_DOUT = 9'h100;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_WAIT_DATA, S_WR_IN, S_GAP, S_POLL, S_RD_OUT
    } state_t;

    // Everything presented to the core for one access, registered as a unit.
    typedef struct packed {
        logic [3:0]  addr;
        logic        rnw;
        logic [31:0] dat;
        logic [3:0]  be;
        logic [8:0]  rdce;
        logic [8:0]  wrce;
    } req_t;

    localparam req_t REQ_IDLE = '{addr: 4'd0, rnw: 1'b1, dat: 32'd0, be: 4'd0,
                                  rdce: 9'd0, wrce: 9'd0};

    function automatic req_t wr_req(input logic [3:0] addr, input logic [31:0] dat,
                                    input logic [3:0] be, input logic [8:0] ce);
        req_t r;
        r      = REQ_IDLE;
        r.addr = addr;
        r.rnw  = 1'b0;
        r.dat  = dat;
        r.be   = be;
        r.wrce = ce;
        return r;
    endfunction

    function automatic req_t rd_req(input logic [3:0] addr, input logic [8:0] ce);
        req_t r;
        r      = REQ_IDLE;
        r.addr = addr;
        r.rdce = ce;
        return r;
    endfunction

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [3:0]  gap_q, gap_d;
    logic [15:0] done_q;

    logic        acc_active, wr_ack, rd_ack, to_expire;
    logic        pop_req, push_res;

    // Input queue
    logic [31:0]      in_mem [DEPTH];
    logic [FIFO_AW:0] in_wp_q, in_rp_q;
    logic             in_empty, in_full, in_push, in_pop;
    logic [31:0]      in_head;

    // Output queue
    logic [31:0]      out_mem [DEPTH];
    logic [FIFO_AW:0] out_wp_q, out_rp_q;
    logic             out_empty, out_full, out_push, out_pop;

    assign in_empty = (in_wp_q == in_rp_q);
    assign in_full  = (in_wp_q[FIFO_AW] != in_rp_q[FIFO_AW]) &&
                      (in_wp_q[FIFO_AW-1:0] == in_rp_q[FIFO_AW-1:0]);
    assign in_push  = s_valid_i && !in_full;
    assign in_pop   = pop_req && !in_empty;
    assign in_head  = in_mem[in_rp_q[FIFO_AW-1:0]];

    assign out_empty = (out_wp_q == out_rp_q);
    assign out_full  = (out_wp_q[FIFO_AW] != out_rp_q[FIFO_AW]) &&
                       (out_wp_q[FIFO_AW-1:0] == out_rp_q[FIFO_AW-1:0]);
    assign out_push  = push_res && !out_full;
    assign out_pop   = m_ready_i && !out_empty;

    assign acc_active = |{req_q.rdce, req_q.wrce};
    assign wr_ack     = (|req_q.wrce) && core_wrack_i;
    assign rd_ack     = (|req_q.rdce) && core_rdack_i;

    // Queue storage: data only, occupancy lives in the pointers.
    // NOTE: the storage arrays carry no reset; an empty queue never exposes them, and
    // leaving them unreset lets them map onto plain RAM/register-file cells.
    always_ff @(posedge bus2ip_clk_i) begin
        if (in_push)
            in_mem[in_wp_q[FIFO_AW-1:0]] <= s_dat_i;
        if (out_push)
            out_mem[out_wp_q[FIFO_AW-1:0]] <= core_dat_i;
    end

    // Queue pointers; reset empties both queues.
    // NOTE: state is updated with non-blocking assignments so every register samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge bus2ip_clk_i or negedge n_rst_s) begin
        if (!n_rst_s) begin
            in_wp_q  <= '0;
            in_rp_q  <= '0;
            out_wp_q <= '0;
            out_rp_q <= '0;
        end else begin
            if (in_push)  in_wp_q  <= in_wp_q + PTR_ONE;
            if (in_pop)   in_rp_q  <= in_rp_q + PTR_ONE;
            if (out_push) out_wp_q <= out_wp_q + PTR_ONE;
            if (out_pop)  out_rp_q <= out_rp_q + PTR_ONE;
        end
    end

`ifdef TRIVIUM_STREAM_TIMEOUT_EN
    localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = 1;

    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;
    logic            acc_ack;

    assign acc_ack   = wr_ack || rd_ack;
    assign to_expire = acc_active && !acc_ack && (to_cnt_q == TO_LAST);
    assign err_o     = err_q;

    // Count the cycles the current request has been waiting; sticky error on expiry.
    always_ff @(posedge bus2ip_clk_i or negedge n_rst_s) begin
        if (!n_rst_s) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (!acc_active || acc_ack || to_expire)
                to_cnt_q <= '0;
            else
                to_cnt_q <= to_cnt_q + TO_ONE;
            if (to_expire)
                err_q <= 1'b1;
        end
    end
`else
    assign to_expire = 1'b0;
    assign err_o     = 1'b0;
`endif

    // FSM state, registered core request and poll-gap counter.
    always_ff @(posedge bus2ip_clk_i or negedge n_rst_s) begin
        if (!n_rst_s) begin
            state_q <= S_IDLE;
            req_q   <= REQ_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            gap_q   <= gap_d;
        end
    end

    // Next state and next request. An access state raises its request one cycle after
    // entry, which provides the idle cycle after the previous ack; POLL is the exception
    // since it is always entered from GAP, which is already idle.
    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        gap_d    = gap_q;
        pop_req  = 1'b0;
        push_res = 1'b0;

        if (to_expire) begin
            state_d = S_IDLE;
            req_d   = REQ_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i)
                        state_d = S_INIT;
                end
                S_INIT: begin
                    if (!acc_active) begin
                        req_d = wr_req(A_CTRL, 32'h0000_0001, 4'b0001, CE_CTRL);
                    end else if (wr_ack) begin
                        req_d   = REQ_IDLE;
                        state_d = S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    if (!in_empty && !out_full)
                        state_d = S_WR_IN;
                end
                S_WR_IN: begin
                    // Held for as long as the core is warming up.
                    if (!acc_active) begin
                        req_d = wr_req(A_DIN, in_head, 4'hF, CE_DIN);
                    end else if (wr_ack) begin
                        req_d   = REQ_IDLE;
                        pop_req = 1'b1;
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q == 4'(POLL_GAP - 1)) begin
                        req_d   = rd_req(A_CTRL, CE_CTRL);
                        state_d = S_POLL;
                    end else begin
                        gap_d = gap_q + 4'd1;
                    end
                end
                S_POLL: begin
                    if (!acc_active) begin
                        req_d = rd_req(A_CTRL, CE_CTRL);
                    end else if (rd_ack) begin
                        req_d = REQ_IDLE;
                        gap_d = '0;
                        // Status bit 8 flags a result waiting at the data-out register.
                        state_d = core_dat_i[8] ? S_RD_OUT : S_GAP;
                    end
                end
                S_RD_OUT: begin
                    if (!acc_active) begin
                        req_d = rd_req(A_DOUT, CE_DOUT);
                    end else if (rd_ack) begin
                        req_d    = REQ_IDLE;
                        push_res = 1'b1;
                        state_d  = S_WAIT_DATA;
                    end
                end
                default: begin
                    req_d   = REQ_IDLE;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Results delivered to the output queue, free-running and wrapping.
    always_ff @(posedge bus2ip_clk_i or negedge n_rst_s) begin
        if (!n_rst_s)
            done_q <= '0;
        else if (out_push)
            done_q <= done_q + 16'd1;
    end

    assign core_addr_o  = req_q.addr;
    assign core_rnw_o   = req_q.rnw;
    assign core_dat_o   = req_q.dat;
    assign core_be_o    = req_q.be;
    assign core_rdce_o  = req_q.rdce;
    assign core_wrce_o  = req_q.wrce;

    assign s_ready_o    = !in_full;
    assign m_valid_o    = !out_empty;
    assign m_dat_o      = out_empty ? 32'd0 : out_mem[out_rp_q[FIFO_AW-1:0]];
    assign busy_o       = (state_q != S_IDLE) && (state_q != S_WAIT_DATA);
    assign words_done_o = done_q;

endmodule

// File: tb/tb_trivium_stream_ctrl.sv
// tb_trivium_stream_ctrl: directed bench for trivium_stream_ctrl with a behavioural
// core model (combinational acks, warm-up after init, 32-cycle computation, toy
// keystream) and a protocol monitor on the core port.
module tb_trivium_stream_ctrl;

`ifdef TRIVIUM_STREAM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 4095;
`endif
    localparam int WARMUP = 1152;
    localparam int CALC   = 32;

    logic        bus2ip_clk_i = 1'b0;
    logic        n_rst_s      = 1'b0;
    logic        start_i      = 1'b0;
    logic [31:0] s_dat_i      = '0;
    logic        s_valid_i    = 1'b0;
    logic        s_ready_o;
    logic [31:0] m_dat_o;
    logic        m_valid_o;
    logic        m_ready_i    = 1'b0;
    logic [3:0]  core_addr_o;
    logic        core_rnw_o;
    logic [31:0] core_dat_o;
    logic [3:0]  core_be_o;
    logic [8:0]  core_rdce_o;
    logic [8:0]  core_wrce_o;
    logic [31:0] core_dat_i;
    logic        core_rdack_i;
    logic        core_wrack_i;
    logic        busy_o;
    logic [15:0] words_done_o;
    logic        err_o;

    trivium_stream_ctrl #(
        .FIFO_AW        (3),
        .POLL_GAP       (4),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .bus2ip_clk_i (bus2ip_clk_i),
        .n_rst_s      (n_rst_s),
        .start_i      (start_i),
        .s_dat_i      (s_dat_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .m_dat_o      (m_dat_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .core_addr_o  (core_addr_o),
        .core_rnw_o   (core_rnw_o),
        .core_dat_o   (core_dat_o),
        .core_be_o    (core_be_o),
        .core_rdce_o  (core_rdce_o),
        .core_wrce_o  (core_wrce_o),
        .core_dat_i   (core_dat_i),
        .core_rdack_i (core_rdack_i),
        .core_wrack_i (core_wrack_i),
        .busy_o       (busy_o),
        .words_done_o (words_done_o),
        .err_o        (err_o)
    );

    always #5 bus2ip_clk_i = ~bus2ip_clk_i;

    // Toy keystream word i (counted from the last init).
    function automatic logic [31:0] ks(input logic [31:0] i);
        logic [31:0] a;
        a = i + 32'd1;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
    endfunction

    // ---------------- core model (not reset by n_rst_s) ----------------
    logic [10:0] warm    = '0;
    logic [5:0]  calc    = '0;
    logic        pending = 1'b0;
    logic [31:0] res     = '0;
    logic [31:0] ks_idx  = '0;
    logic        ack_en  = 1'b1;
    wire         avail   = pending && (calc == 6'd0);

    assign core_wrack_i = ack_en && ((core_wrce_o == 9'h001) ||
                          (core_wrce_o == 9'h080 && warm == 11'd0 && !pending));
    assign core_rdack_i = ack_en && (core_rdce_o == 9'h001 || core_rdce_o == 9'h100);
    assign core_dat_i   = (core_rdce_o == 9'h001) ? {23'd0, avail, 8'd0} :
                          (core_rdce_o == 9'h100) ? res : 32'd0;

    always @(posedge bus2ip_clk_i) begin
        if (warm != 11'd0) warm <= warm - 11'd1;
        if (calc != 6'd0)  calc <= calc - 6'd1;
        if (core_wrce_o == 9'h001 && core_wrack_i && core_dat_o[0]) begin
            warm    <= 11'(WARMUP);
            ks_idx  <= '0;
            pending <= 1'b0;
            calc    <= '0;
        end
        if (core_wrce_o == 9'h080 && core_wrack_i) begin
            res     <= core_dat_o ^ ks(ks_idx);
            ks_idx  <= ks_idx + 32'd1;
            calc    <= 6'(CALC);
            pending <= 1'b1;
        end
        if (core_rdce_o == 9'h100 && core_rdack_i)
            pending <= 1'b0;
    end

    // ---------------- protocol monitor ----------------
    int cyc = 0, viol = 0, wr7_acks = 0, rd8_acks = 0, wr7_hi = 0, last_wr_cyc = 0;
    logic [58:0] prev_req    = '0;
    logic        prev_active = 1'b0;
    logic        prev_ack    = 1'b0;

    wire [58:0] req_now  = {core_addr_o, core_rnw_o, core_dat_o, core_be_o, core_rdce_o, core_wrce_o};
    wire [17:0] ce_now   = {core_rdce_o, core_wrce_o};
    wire        act_now  = (ce_now != 18'd0);
    wire        ack_now  = (|core_wrce_o && core_wrack_i) || (|core_rdce_o && core_rdack_i);
    wire        bad_1hot = act_now && !$onehot(ce_now);
    wire        bad_idle = prev_ack && act_now;
    wire        bad_hold = prev_active && !prev_ack && ack_en && (req_now != prev_req);
    wire        bad_rnw  = (|core_wrce_o && core_rnw_o) || (|core_rdce_o && !core_rnw_o);
    wire        bad_addr = act_now && ((core_rdce_o | core_wrce_o) != (9'd1 << core_addr_o));

    always @(posedge bus2ip_clk_i) cyc <= cyc + 1;

    always @(negedge bus2ip_clk_i) begin
        if (!n_rst_s) begin
            prev_req    <= '0;
            prev_active <= 1'b0;
            prev_ack    <= 1'b0;
        end else begin
            viol <= viol + int'(bad_1hot) + int'(bad_idle) + int'(bad_hold)
                         + int'(bad_rnw) + int'(bad_addr);
            if (core_wrce_o == 9'h080) wr7_hi <= wr7_hi + 1;
            if (core_wrce_o == 9'h080 && core_wrack_i) begin
                wr7_acks    <= wr7_acks + 1;
                last_wr_cyc <= cyc;
            end
            if (core_rdce_o == 9'h100 && core_rdack_i) rd8_acks <= rd8_acks + 1;
            prev_req    <= req_now;
            prev_active <= act_now;
            prev_ack    <= ack_now;
        end
    end

    // ---------------- checking and stimulus helpers ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d, output bit ok);
        ok        = 1'b0;
        s_dat_i   = d;
        s_valid_i = 1'b1;
        for (int k = 0; k < 4000 && !ok; k++) begin
            if (s_ready_o) ok = 1'b1;
            @(negedge bus2ip_clk_i);
        end
        s_valid_i = 1'b0;
    endtask

    task automatic pop_word(output logic [31:0] d, output bit ok);
        ok = 1'b0;
        d  = '0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            if (m_valid_o) begin
                d         = m_dat_o;
                ok        = 1'b1;
                m_ready_i = 1'b1;
            end
            @(negedge bus2ip_clk_i);
        end
        m_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        n_rst_s   = 1'b0;
        s_valid_i = 1'b0;
        m_ready_i = 1'b0;
        start_i   = 1'b0;
        repeat (2) @(negedge bus2ip_clk_i);
        n_rst_s = 1'b1;
        @(negedge bus2ip_clk_i);
    endtask

    // Pulse start and wait for the init write to be raised; returns at that cycle.
    task automatic start_and_wait_req(output bit seen);
        seen    = 1'b0;
        start_i = 1'b1;
        @(negedge bus2ip_clk_i);
        start_i = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (core_wrce_o != 9'd0) seen = 1'b1;
            else @(negedge bus2ip_clk_i);
        end
    endtask

    logic [31:0] pt  [8];
    logic [31:0] ct  [8];
    logic [31:0] pt2 [10];

    initial begin
        logic [31:0] d;
        bit ok, seen;
        int base_wr, base_rd, base_hi, n_ok, lat, held;

        pt = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'hA5A5_5A5A,
               32'h8000_0001, 32'hCAFE_F00D, 32'h0F0F_0F0F, 32'h7654_3210};
        for (int j = 0; j < 10; j++) pt2[j] = 32'h1000_0000 + 32'(j * 32'h0101_0101);

        // Reset with an offered input word.
        n_rst_s   = 1'b0;
        s_valid_i = 1'b1;
        s_dat_i   = 32'hDEAD_BEEF;
        repeat (3) @(negedge bus2ip_clk_i);
        check("rst_s_ready", s_ready_o, 1);
        check("rst_m_valid", m_valid_o, 0);
        check("rst_m_dat", m_dat_o, 0);
        check("rst_ce", {core_rdce_o, core_wrce_o}, 0);
        check("rst_rnw", core_rnw_o, 1);
        check("rst_addr_dat_be", {core_addr_o, core_be_o, core_dat_o[23:0]}, 0);
        check("rst_words_done", words_done_o, 0);
        check("rst_busy_err", {busy_o, err_o}, 0);
        s_valid_i = 1'b0;
        @(negedge bus2ip_clk_i);
        n_rst_s = 1'b1;
        @(negedge bus2ip_clk_i);

        // Init write: single-cycle with immediate ack.
        start_and_wait_req(seen);
        check("init_seen", seen, 1);
        check("init_wrce", core_wrce_o, 9'h001);
        check("init_addr", core_addr_o, 0);
        check("init_dat", core_dat_o, 32'h1);
        check("init_be", core_be_o, 4'b0001);
        check("init_rnw", core_rnw_o, 0);
        check("init_busy", busy_o, 1);
        @(negedge bus2ip_clk_i);
        check("init_dropped", {core_rdce_o, core_wrce_o}, 0);
        check("wait_busy", busy_o, 0);

        // One zero word during warm-up.
        base_wr = wr7_acks;
        base_hi = wr7_hi;
        push_word(32'h0, ok);
        check("c_push", ok, 1);
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            if (m_valid_o) seen = 1'b1;
            else @(negedge bus2ip_clk_i);
        end
        check("c_valid_seen", seen, 1);
        lat = cyc - last_wr_cyc;
        check("c_latency_ge33", lat >= 33, 1);
        check("c_data", m_dat_o, ks(0));
        check("c_words_done", words_done_o, 1);
        check("c_wr_in_once", wr7_acks - base_wr, 1);
        check("c_warmup_hold", (wr7_hi - base_hi) >= 1100, 1);
        pop_word(d, ok);
        repeat (200) @(negedge bus2ip_clk_i);
        check("c_no_repeat", wr7_acks - base_wr, 1);
        check("c_drained", m_valid_o, 0);

        // Eight words back-to-back after a fresh init: queue fills, then drains in order.
        do_reset();
        start_and_wait_req(seen);
        @(negedge bus2ip_clk_i);
        n_ok = 0;
        for (int i = 0; i < 8; i++) begin
            push_word(pt[i], ok);
            n_ok += int'(ok);
        end
        check("d_pushed", n_ok, 8);
        check("d_full", s_ready_o, 0);
        for (int i = 0; i < 8; i++) begin
            pop_word(d, ok);
            ct[i] = d;
            check("d_pop_ok", ok, 1);
            check("d_cipher", d, pt[i] ^ ks(32'(i)));
        end
        check("d_words_done", words_done_o, 8);

        // Same key/IV, feed the ciphertext back: plaintext comes out.
        do_reset();
        start_and_wait_req(seen);
        @(negedge bus2ip_clk_i);
        for (int i = 0; i < 8; i++) push_word(ct[i], ok);
        for (int i = 0; i < 8; i++) begin
            pop_word(d, ok);
            check("e_plain", d, pt[i]);
        end
        check("e_words_done", words_done_o, 8);

        // Backpressure: 10 words with the consumer stalled.
        base_wr = wr7_acks;
        base_rd = rd8_acks;
        n_ok    = 0;
        for (int j = 0; j < 10; j++) begin
            push_word(pt2[j], ok);
            n_ok += int'(ok);
        end
        check("f_pushed", n_ok, 10);
        repeat (1500) @(negedge bus2ip_clk_i);
        check("f_wr_in_8", wr7_acks - base_wr, 8);
        check("f_rd_out_8", rd8_acks - base_rd, 8);
        check("f_words_done", words_done_o, 16);
        check("f_valid_idle", {m_valid_o, busy_o, s_ready_o}, 3'b101);
        for (int j = 0; j < 10; j++) begin
            pop_word(d, ok);
            check("f_order", d, pt2[j] ^ ks(32'(8 + j)));
        end
        check("f_words_done_end", words_done_o, 18);

        // Core never acknowledges.
        do_reset();
        ack_en = 1'b0;
        start_and_wait_req(seen);
        check("g_req_seen", seen, 1);
`ifdef TRIVIUM_STREAM_TIMEOUT_EN
        held = 0;
        while (core_wrce_o != 9'd0 && held < 100) begin
            held++;
            @(negedge bus2ip_clk_i);
        end
        check("g_held_cycles", held, TB_TIMEOUT);
        check("g_err", err_o, 1);
        check("g_idle", busy_o, 0);
`else
        held = 0;
        repeat (1000) @(negedge bus2ip_clk_i);
        check("g_still_held", core_wrce_o, 9'h001);
        check("g_err", err_o, 0);
        check("g_busy", busy_o, 1);
`endif
        ack_en = 1'b1;

        check("protocol_viol", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
